// File: rtl/fpu_result_stage.sv
// fpu_result_stage
//
// Retire stage that sits behind the FPU datapath. Each FPU result is taken in
// over a valid/ready handshake. It is buffered in a small FIFO together with its
// destination tag and exception flags. The entry at the head of the FIFO drives
// the register-file writeback port. When an entry retires, its exception flags
// are OR-ed into the sticky fflags register. Software can also overwrite fflags.
// A flush discards every buffered result.
//
// Configuration macro:
//   FPU_RES_NANBOX_EN - when defined, a single-precision (non-compare) result is
//                       NaN-boxed before it is stored. The stored value is
//                       {32'hFFFF_FFFF, in_result[31:0]}. When the macro is not
//                       defined, in_result is stored exactly as delivered.
//
// Parameters:
//   DEPTH  FIFO entries; must be a power of two and at least 2
//   TAG_W  width of the destination tag
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   in_valid      FPU result valid
//   in_ready      stage can accept a result (depends on registered state only)
//   in_result     FPU result, 64 bits
//   in_flags      {invalid, divbyzero, overflow, underflow, inexact}
//   in_cmp        compare outcome
//   in_is_cmp     op was a compare; writeback data becomes {63'b0, in_cmp}
//   in_is_sp      result is FP32 and sits in bits [31:0]
//   in_tag        destination tag
//   out_valid     writeback entry valid
//   out_ready     writeback port accepts the entry
//   out_data      writeback data
//   out_tag       writeback tag
//   flush         drop all buffered results and any incoming result
//   fflags_we     software write strobe for fflags
//   fflags_wdata  software write value for fflags
//   fflags        sticky accrued exception flags
//   count         current FIFO occupancy, 0..DEPTH

module fpu_result_stage #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned TAG_W = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [63:0]              in_result,
    input  logic [4:0]               in_flags,
    input  logic                     in_cmp,
    input  logic                     in_is_cmp,
    input  logic                     in_is_sp,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [63:0]              out_data,
    output logic [TAG_W-1:0]         out_tag,
    input  logic                     flush,
    input  logic                     fflags_we,
    input  logic [4:0]               fflags_wdata,
    output logic [4:0]               fflags,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    // FIFO storage
    logic [63:0]      data_q  [DEPTH];
    logic [TAG_W-1:0] tag_q   [DEPTH];
    logic [4:0]       flags_q [DEPTH];

    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    // Last head value presented, so the outputs hold steady while empty
    logic [63:0]      hold_data_q;
    logic [TAG_W-1:0] hold_tag_q;

    logic [4:0]       fflags_q, fflags_d;

    logic             empty;
    logic             accept;
    logic             retire;
    logic [63:0]      wr_data;
    logic [4:0]       wr_flags;
    logic [4:0]       head_flags;

    // Handshake decode
    assign empty      = (cnt_q == '0);
    assign in_ready   = (cnt_q < CntW'(DEPTH));
    assign out_valid  = ~empty;
    // An accept in the flush cycle is dropped. A retire in that cycle still completes.
    assign accept     = in_valid & in_ready & ~flush;
    assign retire     = out_valid & out_ready;
    assign head_flags = flags_q[rd_ptr_q];

    // Entry formatting
    always_comb begin
        wr_data = in_result;
        if (in_is_cmp) begin
            wr_data = {63'b0, in_cmp};
        end
`ifdef FPU_RES_NANBOX_EN
        else if (in_is_sp) begin
            wr_data = {32'hFFFF_FFFF, in_result[31:0]};
        end
`endif
    end

    // A compare can only raise invalid; its other flag bits are forced to 0
    assign wr_flags = in_is_cmp ? {in_flags[4], 4'b0000} : in_flags;

`ifndef FPU_RES_NANBOX_EN
    // in_is_sp only affects the data when NaN-boxing is enabled
    logic unused_is_sp;
    assign unused_is_sp = in_is_sp;
`endif

    // Pointer, occupancy and flag next state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (accept) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (retire) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            unique case ({accept, retire})
                2'b10:   cnt_d = cnt_q + CntW'(1);
                2'b01:   cnt_d = cnt_q - CntW'(1);
                default: cnt_d = cnt_q;
            endcase
        end

        // A software write and retire accrual in the same cycle both take effect
        fflags_d = (fflags_we ? fflags_wdata : fflags_q) | (retire ? head_flags : 5'b0);
    end

    // Control state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            fflags_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            fflags_q <= fflags_d;
        end
    end

    // Entry storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_q[i]  <= '0;
                tag_q[i]   <= '0;
                flags_q[i] <= '0;
            end
        end else if (accept) begin
            data_q[wr_ptr_q]  <= wr_data;
            tag_q[wr_ptr_q]   <= in_tag;
            flags_q[wr_ptr_q] <= wr_flags;
        end
    end

    // Output hold registers track the head while the FIFO is not empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_data_q <= '0;
            hold_tag_q  <= '0;
        end else if (!empty) begin
            hold_data_q <= data_q[rd_ptr_q];
            hold_tag_q  <= tag_q[rd_ptr_q];
        end
    end

    assign out_data = empty ? hold_data_q : data_q[rd_ptr_q];
    assign out_tag  = empty ? hold_tag_q  : tag_q[rd_ptr_q];
    assign fflags   = fflags_q;
    assign count    = cnt_q;

endmodule

// File: tb/tb_fpu_result_stage.sv
module tb_fpu_result_stage;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned TAG_W = 5;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [63:0]      in_result;
    logic [4:0]       in_flags;
    logic             in_cmp;
    logic             in_is_cmp;
    logic             in_is_sp;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_data;
    logic [TAG_W-1:0] out_tag;
    logic             flush;
    logic             fflags_we;
    logic [4:0]       fflags_wdata;
    logic [4:0]       fflags;
    logic [CW-1:0]    count;

    fpu_result_stage #(
        .DEPTH(DEPTH),
        .TAG_W(TAG_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_result   (in_result),
        .in_flags    (in_flags),
        .in_cmp      (in_cmp),
        .in_is_cmp   (in_is_cmp),
        .in_is_sp    (in_is_sp),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_tag     (out_tag),
        .flush       (flush),
        .fflags_we   (fflags_we),
        .fflags_wdata(fflags_wdata),
        .fflags      (fflags),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0]      data;
        logic [TAG_W-1:0] tag;
        logic [4:0]       flags;
    } exp_t;

    exp_t             exp_q[$];
    logic [4:0]       ff_model;
    logic [4:0]       ret_flags;
    logic [63:0]      last_data;
    logic [TAG_W-1:0] last_tag;
    int               n_checks;
    int               n_fail;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: what a writeback entry should hold for a given FPU result
    function automatic exp_t model(input logic [63:0] res, input logic [4:0] fl,
                                   input logic cmp, input logic is_cmp, input logic is_sp,
                                   input logic [TAG_W-1:0] tg);
        exp_t e;
        e.tag = tg;
        if (is_cmp) begin
            e.data  = 64'(cmp);
            e.flags = fl & 5'b10000;
        end else begin
            e.data  = res;
`ifdef FPU_RES_NANBOX_EN
            if (is_sp) e.data = {32'hFFFF_FFFF, res[31:0]};
`else
            if (is_sp) e.data = res;
`endif
            e.flags = fl;
        end
        return e;
    endfunction

    // Monitor: compares the head against the scoreboard and pops on retire
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            ret_flags = 5'b0;
            chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                e = exp_q[0];
                chk("out_data", out_data, e.data);
                chk("out_tag", 64'(out_tag), 64'(e.tag));
                last_data = e.data;
                last_tag  = e.tag;
                if (out_ready) begin
                    ret_flags = e.flags;
                    e = exp_q.pop_front();
                end
            end else begin
                chk("hold_data", out_data, last_data);
                chk("hold_tag", 64'(out_tag), 64'(last_tag));
            end
        end
    end

    // Driver: one clock cycle of stimulus, plus the scoreboard push for that cycle
    task automatic step(input logic iv, input logic [63:0] res, input logic [4:0] fl,
                        input logic cmp, input logic icmp, input logic isp,
                        input logic [TAG_W-1:0] tg, input logic ordy, input logic flsh,
                        input logic we, input logic [4:0] wd, output logic acc);
        int sz;
        @(posedge clk);
        #1;
        in_valid     = iv;
        in_result    = res;
        in_flags     = fl;
        in_cmp       = cmp;
        in_is_cmp    = icmp;
        in_is_sp     = isp;
        in_tag       = tg;
        out_ready    = ordy;
        flush        = flsh;
        fflags_we    = we;
        fflags_wdata = wd;
        sz = exp_q.size();
        chk("in_ready", 64'(in_ready), 64'(sz < int'(DEPTH)));
        chk("count", 64'(count), 64'(sz));
        chk("fflags", 64'(fflags), 64'(ff_model));
        #6;  // after the monitor has handled this cycle's retire
        if (flsh) exp_q.delete();
        acc = iv && !flsh && (sz < int'(DEPTH));
        if (acc) exp_q.push_back(model(res, fl, cmp, icmp, isp, tg));
        ff_model = (we ? wd : ff_model) | ret_flags;
    endtask

    task automatic idle(input logic ordy);
        logic acc;
        step(1'b0, 64'h0, 5'h0, 1'b0, 1'b0, 1'b0, '0, ordy, 1'b0, 1'b0, 5'h0, acc);
    endtask

    task automatic push(input logic [63:0] res, input logic [4:0] fl, input logic cmp,
                        input logic icmp, input logic isp, input logic [TAG_W-1:0] tg,
                        input logic ordy);
        logic acc;
        step(1'b1, res, fl, cmp, icmp, isp, tg, ordy, 1'b0, 1'b0, 5'h0, acc);
    endtask

    initial begin
        logic acc;
        n_checks  = 0;
        n_fail    = 0;
        ff_model  = 5'b0;
        ret_flags = 5'b0;
        last_data = 64'h0;
        last_tag  = '0;
        rst = 1'b1;
        in_valid = 1'b0; in_result = 64'h0; in_flags = 5'h0; in_cmp = 1'b0;
        in_is_cmp = 1'b0; in_is_sp = 1'b0; in_tag = '0; out_ready = 1'b0;
        flush = 1'b0; fflags_we = 1'b0; fflags_wdata = 5'h0;
        #23;
        rst = 1'b0;

        // Reset then idle
        repeat (2) idle(1'b0);

        // Single result, retired immediately, accrues inexact
        push(64'h3FF0_0000_0000_0000, 5'b00001, 1'b0, 1'b0, 1'b0, 5'd3, 1'b1);
        repeat (2) idle(1'b1);

        // Back-pressure: fill, then hold a third result until space frees
        push(64'hAAAA_0000_0000_0001, 5'b00010, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0);
        push(64'hBBBB_0000_0000_0002, 5'b00100, 1'b0, 1'b0, 1'b0, 5'd2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 64'hCCCC_0000_0000_0003, 5'b01000, 1'b0, 1'b0, 1'b0, 5'd4,
                 1'b0, 1'b0, 1'b0, 5'h0, acc);
            chk("held_not_accepted", 64'(acc), 64'(0));
        end
        acc = 1'b0;
        for (int i = 0; i < 4 && !acc; i++) begin
            step(1'b1, 64'hCCCC_0000_0000_0003, 5'b01000, 1'b0, 1'b0, 1'b0, 5'd4,
                 1'b1, 1'b0, 1'b0, 5'h0, acc);
        end
        if (!acc) chk("third_accept_timeout", 64'(0), 64'(1));
        repeat (3) idle(1'b1);

        // Compare op with junk result and junk non-invalid flags
        push(64'hDEAD_BEEF_CAFE_F00D, 5'b11111, 1'b1, 1'b1, 1'b0, 5'd7, 1'b1);
        repeat (2) idle(1'b1);

        // Software write cleared and retire accrual in the same cycle
        step(1'b0, 64'h0, 5'h0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 5'b00001, acc);
        push(64'h1234_5678_9ABC_DEF0, 5'b10000, 1'b0, 1'b0, 1'b0, 5'd9, 1'b0);
        step(1'b0, 64'h0, 5'h0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1, 5'b00000, acc);
        idle(1'b0);

        // Flush with two entries plus a concurrent push; nothing retires
        push(64'h1111_1111_1111_1111, 5'b00011, 1'b0, 1'b0, 1'b0, 5'd10, 1'b0);
        push(64'h2222_2222_2222_2222, 5'b00101, 1'b0, 1'b0, 1'b0, 5'd11, 1'b0);
        step(1'b1, 64'h3333_3333_3333_3333, 5'b00110, 1'b0, 1'b0, 1'b0, 5'd12,
             1'b0, 1'b1, 1'b0, 5'h0, acc);
        repeat (2) idle(1'b1);

        // FP32 result
        push(64'h0000_0000_3F80_0000, 5'b00000, 1'b0, 1'b0, 1'b1, 5'd13, 1'b1);
        push(64'h5555_6666_4049_0FDB, 5'b00001, 1'b0, 1'b0, 1'b1, 5'd14, 1'b1);
        repeat (2) idle(1'b1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0, {$urandom, $urandom},
                 5'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
                 1'($urandom), TAG_W'($urandom), 1'($urandom),
                 ($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0, 5'($urandom), acc);
        end

        // Asynchronous reset mid-operation
        push(64'h7777_0000_0000_0007, 5'b11111, 1'b0, 1'b0, 1'b0, 5'd5, 1'b0);
        push(64'h8888_0000_0000_0008, 5'b00001, 1'b0, 1'b0, 1'b0, 5'd6, 1'b0);
        step(1'b0, 64'h0, 5'h0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 5'b11111, acc);
        @(posedge clk);
        #1;
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; fflags_we = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data", out_data, 64'h0);
        chk("rst_out_tag", 64'(out_tag), 64'(0));
        chk("rst_fflags", 64'(fflags), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        exp_q.delete();
        ff_model  = 5'b0;
        last_data = 64'h0;
        last_tag  = '0;
        #1;
        rst = 1'b0;

        push(64'h9999_0000_0000_0009, 5'b00100, 1'b0, 1'b0, 1'b0, 5'd8, 1'b1);
        repeat (4) idle(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
